decode_stage: RTL and testbench

- Registered RV32I decode stage. Sits between instruction fetch and the immediate generator / register file / execute stage.
- Accepts fetched {instruction, pc} over a valid/ready handshake and decodes the opcode into the immediate-select code, register indices and control flags.
- Holds the result in a single-entry pipeline register with stall, flush and illegal-instruction trap handling.

---
 rtl/decode_pkg.sv | 42 ++++
 rtl/decode_logic.sv | 72 +++++++
 rtl/decode_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg
// Shared definitions for the RV32I decode stage: major opcodes, immediate
// select codes understood by the immediate generator, FSM state type and the
// decoded-control bundle carried in the pipeline register.
package decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [3:0] IMM_SEL_I    = 4'd0;
  localparam logic [3:0] IMM_SEL_S    = 4'd1;
  localparam logic [3:0] IMM_SEL_B    = 4'd2;
  localparam logic [3:0] IMM_SEL_J    = 4'd3;
  localparam logic [3:0] IMM_SEL_U    = 4'd4;
  localparam logic [3:0] IMM_SEL_NONE = 4'd15;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] imm_select;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{imm_select: IMM_SEL_NONE, default: 1'b0};

endpackage

// File: rtl/decode_logic.sv
// decode_logic
// Purely combinational opcode decoder. Maps the major opcode and funct3 of an
// RV32I instruction to the control bundle and an illegal-instruction flag.
// Ports:
//   i_opcode  instruction[6:0]
//   i_funct3  instruction[14:12]
//   o_ctrl    decoded immediate select and control flags
//   o_illegal instruction is not a supported RV32I encoding
module decode_logic
  import decode_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  // Known opcodes with a reserved funct3 keep their opcode's decode; only the
  // illegal flag is raised, so the trap handler still sees a sensible bundle.
  always_comb begin
    o_ctrl    = CTRL_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OPC_LUI, OPC_AUIPC: begin
        o_ctrl.imm_select = IMM_SEL_U;
        o_ctrl.reg_write  = 1'b1;
      end
      OPC_JAL: begin
        o_ctrl.imm_select = IMM_SEL_J;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jump       = 1'b1;
      end
      OPC_JALR: begin
        o_ctrl.imm_select = IMM_SEL_I;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jump       = 1'b1;
        o_illegal         = (i_funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        o_ctrl.imm_select = IMM_SEL_B;
        o_ctrl.branch     = 1'b1;
        o_illegal         = (i_funct3 == 3'd2) || (i_funct3 == 3'd3);
      end
      OPC_LOAD: begin
        o_ctrl.imm_select = IMM_SEL_I;
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_read   = 1'b1;
        o_illegal         = (i_funct3 == 3'd3) || (i_funct3 == 3'd6) ||
                            (i_funct3 == 3'd7);
      end
      OPC_STORE: begin
        o_ctrl.imm_select = IMM_SEL_S;
        o_ctrl.mem_write  = 1'b1;
        o_illegal         = (i_funct3 > 3'd2);
      end
      OPC_OP_IMM: begin
        o_ctrl.imm_select = IMM_SEL_I;
        o_ctrl.reg_write  = 1'b1;
      end
      OPC_OP: begin
        o_ctrl.reg_write  = 1'b1;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        o_ctrl.imm_select = IMM_SEL_I;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Registered RV32I decode stage with a single-entry output register,
// valid/ready handshake on both sides, flush and illegal-instruction trap.
// Optional macro DECODE_PERF_CNT_EN adds decoded/stall/flush counters.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           fetch handshake; in_instruction, in_pc payload
//   flush                       squash held entry and same-cycle input
//   out_valid/out_ready         downstream handshake
//   out_instruction, out_pc     registered payload
//   imm_select, rs1, rs2, rd    decoded fields
//   reg_write .. jump, illegal  decoded control flags
//   trap_ack                    trap handler has taken the illegal entry
//   decoded_count, stall_count, flush_count  (DECODE_PERF_CNT_EN only)
//
// state   | meaning
// ST_RUN  | normal decode, accepts when the output register is free
// ST_TRAP | illegal entry consumed; stage blocked until trap_ack or flush
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instruction,
  input  logic [PC_WIDTH-1:0] in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instruction,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [3:0]          imm_select,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                jump,
  output logic                illegal,
  input  logic                trap_ack
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] decoded_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
`endif
);

  state_t              r_state;
  logic                r_out_valid;
  logic                r_illegal;
  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc;
  ctrl_t               r_ctrl;

  ctrl_t w_ctrl;
  logic  w_illegal;
  logic  w_accept;
  logic  w_consume;

  decode_logic u_decode_logic (
    .i_opcode  (in_instruction[6:0]),
    .i_funct3  (in_instruction[14:12]),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  assign in_ready  = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_consume = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_ctrl      <= CTRL_NONE;
    end else if (flush) begin
      // Flush wins over consume: an illegal entry flushed in the same cycle
      // it is consumed never raises a trap.
      r_state     <= ST_RUN;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_consume && r_illegal) begin
            // Anything fetched behind the illegal instruction is younger than
            // the trap and is discarded; the handler redirects fetch.
            r_state     <= ST_TRAP;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_illegal   <= w_illegal;
            r_instr     <= in_instruction;
            r_pc        <= in_pc;
            r_ctrl      <= w_ctrl;
          end else if (w_consume) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign out_valid       = r_out_valid;
  assign illegal         = r_illegal;
  assign out_instruction = r_instr;
  assign out_pc          = r_pc;
  assign imm_select      = r_ctrl.imm_select;
  assign reg_write       = r_ctrl.reg_write;
  assign mem_read        = r_ctrl.mem_read;
  assign mem_write       = r_ctrl.mem_write;
  assign branch          = r_ctrl.branch;
  assign jump            = r_ctrl.jump;
  assign rs1             = r_instr[19:15];
  assign rs2             = r_instr[24:20];
  assign rd              = r_instr[11:7];

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_decoded_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_decoded_cnt <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_decoded_cnt <= r_decoded_cnt + 1'b1;
      end
      if (in_valid && !in_ready && !flush) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (flush) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign decoded_count = r_decoded_cnt;
  assign stall_count   = r_stall_cnt;
  assign flush_count   = r_flush_cnt;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Directed and randomized checks of decode_stage against a behavioural model.
module tb_decode_stage;

  localparam int PW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]   in_instruction, out_instruction;
  logic [PW-1:0] in_pc, out_pc;
  logic [3:0]    imm_select;
  logic [4:0]    rs1, rs2, rd;
  logic          reg_write, mem_read, mem_write, branch, jump, illegal, trap_ack;
`ifdef DECODE_PERF_CNT_EN
  logic [CW-1:0] decoded_count, stall_count, flush_count;
`endif

  always #5 clk = ~clk;

  decode_stage #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .imm_select(imm_select), .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .illegal(illegal), .trap_ack(trap_ack)
`ifdef DECODE_PERF_CNT_EN
    , .decoded_count(decoded_count), .stall_count(stall_count),
    .flush_count(flush_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_valid, m_ill, m_trap;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [3:0]  m_imm;
  logic [4:0]  m_flags;  // {reg_write, mem_read, mem_write, branch, jump}
  longint      m_dec, m_stall, m_flush;

  logic [6:0] opc_pool [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [31:0] ins,
                                     output logic [3:0] imm,
                                     output logic [4:0] fl,
                                     output logic ill);
    int f3;
    f3  = int'(ins[14:12]);
    ill = 1'b0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin imm = 4; fl = 5'b10000; end
      7'b1101111: begin imm = 3; fl = 5'b10001; end
      7'b1100111: begin imm = 0; fl = 5'b10001; ill = (f3 != 0); end
      7'b1100011: begin imm = 2; fl = 5'b00010; ill = f3 inside {2, 3}; end
      7'b0000011: begin imm = 0; fl = 5'b11000; ill = f3 inside {3, 6, 7}; end
      7'b0100011: begin imm = 1; fl = 5'b00100; ill = (f3 > 2); end
      7'b0010011: begin imm = 0; fl = 5'b10000; end
      7'b0110011: begin imm = 15; fl = 5'b10000; end
      7'b0001111, 7'b1110011: begin imm = 0; fl = 5'b00000; end
      default: begin imm = 15; fl = 5'b00000; ill = 1'b1; end
    endcase
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("illegal", illegal, m_ill);
    chk("out_instruction", out_instruction, m_instr);
    chk("out_pc", out_pc, m_pc);
    chk("imm_select", imm_select, m_imm);
    chk("rs1", rs1, m_instr[19:15]);
    chk("rs2", rs2, m_instr[24:20]);
    chk("rd", rd, m_instr[11:7]);
    chk("flags", {reg_write, mem_read, mem_write, branch, jump}, m_flags);
`ifdef DECODE_PERF_CNT_EN
    chk("decoded_count", decoded_count, m_dec[CW-1:0]);
    chk("stall_count", stall_count, m_stall[CW-1:0]);
    chk("flush_count", flush_count, m_flush[CW-1:0]);
`endif
  endtask

  // One clock: drive at the falling edge, check in_ready, update model on the
  // rising edge, then check registered outputs.
  task automatic step(input bit rst, input bit iv, input logic [31:0] ins,
                      input logic [31:0] pc, input bit fl, input bit ordy,
                      input bit tack);
    bit rdy, acc, cons;
    logic [3:0] imm;
    logic [4:0] f;
    logic il;
    @(negedge clk);
    reset = rst; in_valid = iv; in_instruction = ins; in_pc = pc;
    flush = fl; out_ready = ordy; trap_ack = tack;
    #1;
    rdy = !m_trap && (!m_valid || ordy);
    if (!rst) chk("in_ready", in_ready, rdy);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_ill = 0; m_trap = 0; m_instr = '0; m_pc = '0;
      m_imm = 15; m_flags = '0; m_dec = 0; m_stall = 0; m_flush = 0;
    end else begin
      acc  = iv && rdy && !fl;
      cons = m_valid && ordy;
      if (acc) m_dec++;
      if (iv && !rdy && !fl) m_stall++;
      if (fl) m_flush++;
      if (fl) begin
        m_valid = 0; m_ill = 0; m_trap = 0;
      end else if (m_trap) begin
        if (tack) m_trap = 0;
      end else if (cons && m_ill) begin
        m_trap = 1; m_valid = 0; m_ill = 0;
      end else if (acc) begin
        ref_decode(ins, imm, f, il);
        m_valid = 1; m_ill = il; m_instr = ins; m_pc = pc;
        m_imm = imm; m_flags = f;
      end else if (cons) begin
        m_valid = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  logic [31:0] dir_ins [5] = '{32'h00112623, 32'hFE000EE3, 32'h008000EF,
                               32'h123452B7, 32'h002081B3};
  logic [3:0]  dir_imm [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd15};
  logic [4:0]  dir_fl  [5] = '{5'b00100, 5'b00010, 5'b10001, 5'b10000,
                               5'b10000};

  initial begin
    logic [31:0] ins, held;
    reset = 1; in_valid = 0; in_instruction = '0; in_pc = '0;
    flush = 0; out_ready = 0; trap_ack = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_imm_select", imm_select, 4'd15);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("rst_in_ready", in_ready, 1'b1);

    // addi x1, x0, 5
    step(0, 1, 32'h00500093, 32'h100, 0, 1, 0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_imm", imm_select, 4'd0);
    chk("addi_rd", rd, 5'd1);
    chk("addi_rs1", rs1, 5'd0);
    chk("addi_reg_write", reg_write, 1'b1);
    chk("addi_illegal", illegal, 1'b0);

    // Back-to-back, one per cycle
    for (int i = 0; i < 5; i++) begin
      step(0, 1, dir_ins[i], 32'h104 + 32'(4 * i), 0, 1, 0);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_imm", imm_select, dir_imm[i]);
      chk("b2b_flags", {reg_write, mem_read, mem_write, branch, jump},
          dir_fl[i]);
    end

    // Stall for three cycles: outputs stay on the add entry
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h00000013, 32'h200, 0, 0, 0);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold", out_instruction, 32'h002081B3);
    end
    step(0, 1, 32'h00000013, 32'h200, 0, 1, 0);
    chk("release_accept", out_instruction, 32'h00000013);

    // Illegal instruction and trap
    step(0, 1, 32'hFFFFFFFF, 32'h300, 0, 1, 0);
    chk("illegal_flag", illegal, 1'b1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("trap_out_valid", out_valid, 1'b0);
    step(0, 1, 32'h00000013, 32'h304, 0, 1, 0);
    step(0, 1, 32'h00000013, 32'h304, 0, 1, 0);
    chk("trap_in_ready", in_ready, 1'b0);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("trap_ack_ready", in_ready, 1'b1);

    // Flush with a held entry and a same-cycle input
    step(0, 1, 32'h002081B3, 32'h400, 0, 0, 0);
    held = out_instruction;
    step(0, 1, 32'h123452B7, 32'h404, 1, 1, 0);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_not_loaded", out_instruction, 32'h002081B3);

    // Flush while trapped
    step(0, 1, 32'h0000007F, 32'h500, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("pre_flush_trap", in_ready, 1'b0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("flush_leaves_trap", in_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      ins = $urandom;
      if ($urandom_range(7) != 0) ins[6:0] = opc_pool[$urandom_range(11)];
      step($urandom_range(199) == 0, $urandom_range(3) != 0, ins, $urandom,
           $urandom_range(15) == 0, $urandom_range(3) != 0,
           $urandom_range(3) == 0);
    end

`ifdef DECODE_PERF_CNT_EN
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 32'h00500093, 32'(i), 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h00500093, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 0, 0);
    chk("perf_decoded", decoded_count, 32'd10);
    chk("perf_stall", stall_count, 32'd4);
    chk("perf_flush", flush_count, 32'd2);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("perf_rst", {decoded_count, stall_count, flush_count}, 96'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
